// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: state encoding,
// digit width and the digit-count rule used to validate DIGITS.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int BCD_DIGIT_W = 4;

    // Number of decimal digits needed to print 2^width-1.
    function automatic int bcd_digits(input int width);
        longint max_val;
        int     n;
        max_val = (longint'(1) << width) - 1;
        n       = 1;
        while (max_val >= 10) begin
            max_val = max_val / 10;
            n       = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bcd_converter_if.sv
// Valid/ready bundle between the value producer, the converter and the
// display driver; slave is the converter side.
interface bcd_converter_if
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                            i_Valid;
    logic [WIDTH-1:0]                i_Value;
    logic                            o_Ready;
    logic                            o_Valid;
    logic [BCD_DIGIT_W*DIGITS-1:0]   o_Bcd;
    logic                            i_Ready;
    logic                            o_Busy;

    modport slave (
        input  i_Valid, i_Value, i_Ready,
        output o_Ready, o_Valid, o_Bcd, o_Busy
    );

    modport master (
        output i_Valid, i_Value, i_Ready,
        input  o_Ready, o_Valid, o_Bcd, o_Busy
    );
endinterface

// File: rtl/bcd_digit_adjust.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_DIGIT_W'(5)) begin
            digit_out = digit_in + BCD_DIGIT_W'(3);
        end
    end
endmodule

// File: rtl/bcd_converter.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// The published result only updates when a conversion completes.
module bcd_converter
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic           i_Clock,
    input  logic           i_Reset_n,
    bcd_converter_if.slave bus
);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("bcd_converter: WIDTH must be within 4..16");
        end
        if (DIGITS != bcd_digits(WIDTH)) begin : g_bad_digits
            $error("bcd_converter: DIGITS does not match WIDTH");
        end
    endgenerate

    state_t            state_reg;
    logic [WIDTH-1:0]  shift_reg;
    logic [BCD_W-1:0]  scratch_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [BCD_W-1:0]  bcd_reg;
    logic              ready_reg;
    logic              valid_reg;
    logic              busy_reg;

    logic [BCD_W-1:0]  adj_scratch;
    logic [BCD_W-1:0]  scratch_next;
    logic [WIDTH-1:0]  shift_next;
    logic              unused_top_bit;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .digit_in  (scratch_reg[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .digit_out (adj_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // The top digit never reaches 8 for a legal DIGITS, so its MSB shifts out as 0.
    assign unused_top_bit = adj_scratch[BCD_W-1];
    assign scratch_next   = {adj_scratch[BCD_W-2:0], shift_reg[WIDTH-1]};
    assign shift_next     = {shift_reg[WIDTH-2:0], 1'b0};

    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            bcd_reg     <= '0;
            ready_reg   <= 1'b1;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.i_Valid) begin
                        shift_reg   <= bus.i_Value;
                        scratch_reg <= '0;
                        cnt_reg     <= CNT_W'(WIDTH);
                        state_reg   <= SHIFT;
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                    end
                end
                SHIFT: begin
                    scratch_reg <= scratch_next;
                    shift_reg   <= shift_next;
                    cnt_reg     <= cnt_reg - 1'b1;
                    // Last shift: publish the freshly shifted digits, not the stale scratch.
                    if (cnt_reg == CNT_W'(1)) begin
                        bcd_reg   <= scratch_next;
                        state_reg <= DONE;
                        busy_reg  <= 1'b0;
                        valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.i_Ready) begin
                        state_reg <= IDLE;
                        valid_reg <= 1'b0;
                        ready_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    ready_reg <= 1'b1;
                    valid_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Ready = ready_reg;
    assign bus.o_Valid = valid_reg;
    assign bus.o_Busy  = busy_reg;
    assign bus.o_Bcd   = bcd_reg;

endmodule

// File: tb/tb_bcd_converter.sv
// Scoreboard bench for bcd_converter: 8-bit and 16-bit instances share clock
// and reset; expected digits are derived by decimal division.
module tb_bcd_converter;
    import bcd_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_converter_if #(.WIDTH(8),  .DIGITS(3)) m8 ();
    bcd_converter_if #(.WIDTH(16), .DIGITS(5)) m16 ();

    bcd_converter #(.WIDTH(8), .DIGITS(3)) dut8 (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (m8.slave)
    );

    bcd_converter #(.WIDTH(16), .DIGITS(5)) dut16 (
        .i_Clock   (clk),
        .i_Reset_n (rst_n),
        .bus       (m16.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [11:0] q8[$];
    logic [19:0] q16[$];

    function automatic logic [19:0] to_bcd(input int v);
        logic [19:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic drive8(input int v);
        int          k;
        logic [19:0] full;
        k = 0;
        @(negedge clk);
        m8.i_Valid = 1'b1;
        m8.i_Value = 8'(v);
        while (!m8.o_Ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (m8.o_Ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_timeout8 value=%0d o_Ready=%b required=1", v, m8.o_Ready);
        end
        @(posedge clk);
        full = to_bcd(v);
        q8.push_back(full[11:0]);
        #1 m8.i_Valid = 1'b0;
    endtask

    task automatic drive16(input int v);
        int k;
        k = 0;
        @(negedge clk);
        m16.i_Valid = 1'b1;
        m16.i_Value = 16'(v);
        while (!m16.o_Ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (m16.o_Ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_timeout16 value=%0d o_Ready=%b required=1", v, m16.o_Ready);
        end
        @(posedge clk);
        q16.push_back(to_bcd(v));
        #1 m16.i_Valid = 1'b0;
    endtask

    // Negedges counted from the first one after the call until o_Valid (0 = already valid).
    task automatic wait_valid8(output int lat);
        lat = 0;
        @(negedge clk);
        while (!m8.o_Valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_valid16(output int lat);
        lat = 0;
        @(negedge clk);
        while (!m16.o_Valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        m8.i_Valid = 1'b0;  m8.i_Value = '0;  m8.i_Ready = 1'b1;
        m16.i_Valid = 1'b0; m16.i_Value = '0; m16.i_Ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (m8.o_Ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", m8.o_Ready); end
        n_cmp++; if (m8.o_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b want=0", m8.o_Valid); end
        n_cmp++; if (m8.o_Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", m8.o_Busy); end
        n_cmp++; if (m8.o_Bcd !== 12'h000) begin n_bad++; $display("FAIL reset_bcd got=%h want=000", m8.o_Bcd); end
        n_cmp++; if (m16.o_Bcd !== 20'h00000 || m16.o_Ready !== 1'b1) begin
            n_bad++; $display("FAIL reset16 bcd=%h ready=%b want bcd=00000 ready=1", m16.o_Bcd, m16.o_Ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_cmp++; if (m8.o_Ready !== 1'b1 || m8.o_Valid !== 1'b0) begin
            n_bad++; $display("FAIL post_reset_idle ready=%b valid=%b want ready=1 valid=0", m8.o_Ready, m8.o_Valid);
        end
        $display("test_reset done");
    endtask

    task automatic test_zero();
        int          lat;
        logic [11:0] exp;
        m8.i_Ready = 1'b1;
        drive8(0);
        wait_valid8(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL zero_latency got=%0d want=8", lat); end
        exp = (q8.size() != 0) ? q8.pop_front() : 12'hxxx;
        n_cmp++; if (m8.o_Bcd !== exp) begin n_bad++; $display("FAIL zero_bcd got=%h want=%h", m8.o_Bcd, exp); end
        n_cmp++; if (m8.o_Ready !== 1'b0) begin n_bad++; $display("FAIL zero_ready_in_done got=%b want=0", m8.o_Ready); end
        @(negedge clk);
        n_cmp++; if (m8.o_Ready !== 1'b1 || m8.o_Valid !== 1'b0) begin
            n_bad++; $display("FAIL zero_ready_return ready=%b valid=%b want ready=1 valid=0", m8.o_Ready, m8.o_Valid);
        end
        $display("test_zero value=0 bcd=%h latency=%0d", m8.o_Bcd, lat);
    endtask

    task automatic test_values();
        int          vals[2] = '{255, 144};
        int          lat;
        logic [11:0] exp;
        m8.i_Ready = 1'b1;
        foreach (vals[i]) begin
            drive8(vals[i]);
            @(negedge clk);
            n_cmp++; if (m8.o_Busy !== 1'b1 || m8.o_Ready !== 1'b0) begin
                n_bad++; $display("FAIL shift_flags busy=%b ready=%b want busy=1 ready=0", m8.o_Busy, m8.o_Ready);
            end
            wait_valid8(lat);
            n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL value_latency got=%0d want=7", lat); end
            exp = (q8.size() != 0) ? q8.pop_front() : 12'hxxx;
            n_cmp++; if (m8.o_Bcd !== exp) begin n_bad++; $display("FAIL value_bcd value=%0d got=%h want=%h", vals[i], m8.o_Bcd, exp); end
            $display("test_values value=%0d bcd=%h", vals[i], m8.o_Bcd);
        end
        @(negedge clk);
    endtask

    task automatic test_fib_sequence();
        int fib[11] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89};
        m8.i_Ready = 1'b1;
        fork
            begin
                foreach (fib[i]) drive8(fib[i]);
            end
            begin
                int          k;
                time         t_prev;
                logic [11:0] exp;
                t_prev = 0;
                for (int i = 0; i < 11; i++) begin
                    k = 0;
                    @(negedge clk);
                    while (!m8.o_Valid && k < 200) begin
                        @(negedge clk);
                        k++;
                    end
                    exp = (q8.size() != 0) ? q8.pop_front() : 12'hxxx;
                    n_cmp++; if (m8.o_Valid !== 1'b1 || m8.o_Bcd !== exp) begin
                        n_bad++; $display("FAIL fib_bcd idx=%0d valid=%b got=%h want=%h", i, m8.o_Valid, m8.o_Bcd, exp);
                    end
                    if (i > 0) begin
                        n_cmp++; if ($time - t_prev !== 100) begin
                            n_bad++; $display("FAIL fib_period idx=%0d got=%0t want=100", i, $time - t_prev);
                        end
                    end
                    t_prev = $time;
                    $display("test_fib idx=%0d value=%0d bcd=%h", i, fib[i], m8.o_Bcd);
                end
            end
        join
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int          lat;
        logic [11:0] exp;
        logic        extra;
        m8.i_Ready = 1'b0;
        drive8(89);
        wait_valid8(lat);
        n_cmp++; if (lat !== 8) begin n_bad++; $display("FAIL bp_latency got=%0d want=8", lat); end
        repeat (5) begin
            @(negedge clk);
            n_cmp++; if (m8.o_Valid !== 1'b1 || m8.o_Bcd !== 12'h089 || m8.o_Ready !== 1'b0) begin
                n_bad++; $display("FAIL bp_hold valid=%b bcd=%h ready=%b want valid=1 bcd=089 ready=0",
                                  m8.o_Valid, m8.o_Bcd, m8.o_Ready);
            end
        end
        m8.i_Ready = 1'b1;
        exp = (q8.size() != 0) ? q8.pop_front() : 12'hxxx;
        n_cmp++; if (m8.o_Bcd !== exp) begin n_bad++; $display("FAIL bp_bcd got=%h want=%h", m8.o_Bcd, exp); end
        @(negedge clk);
        n_cmp++; if (m8.o_Valid !== 1'b0 || m8.o_Ready !== 1'b1) begin
            n_bad++; $display("FAIL bp_consume valid=%b ready=%b want valid=0 ready=1", m8.o_Valid, m8.o_Ready);
        end
        extra = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (m8.o_Valid) extra = 1'b1;
        end
        n_cmp++; if (extra !== 1'b0) begin n_bad++; $display("FAIL bp_once extra_valid=%b want=0", extra); end
        $display("test_backpressure value=89 bcd=%h", m8.o_Bcd);
    endtask

    task automatic test_busy_reject();
        int          lat;
        logic [11:0] exp;
        logic [19:0] full;
        m8.i_Ready = 1'b1;
        drive8(89);
        repeat (3) @(negedge clk);
        m8.i_Valid = 1'b1;
        m8.i_Value = 8'd55;
        lat = 0;
        while (!m8.o_Valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        exp = (q8.size() != 0) ? q8.pop_front() : 12'hxxx;
        n_cmp++; if (m8.o_Bcd !== exp) begin n_bad++; $display("FAIL busy_first_bcd got=%h want=%h", m8.o_Bcd, exp); end
        n_cmp++; if (m8.o_Ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready_in_done got=%b want=0", m8.o_Ready); end
        @(negedge clk);
        n_cmp++; if (m8.o_Ready !== 1'b1 || m8.o_Valid !== 1'b0) begin
            n_bad++; $display("FAIL busy_idle ready=%b valid=%b want ready=1 valid=0", m8.o_Ready, m8.o_Valid);
        end
        @(posedge clk);
        full = to_bcd(55);
        q8.push_back(full[11:0]);
        #1 m8.i_Valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (m8.o_Bcd !== 12'h089 || m8.o_Busy !== 1'b1) begin
            n_bad++; $display("FAIL busy_hold_old bcd=%h busy=%b want bcd=089 busy=1", m8.o_Bcd, m8.o_Busy);
        end
        wait_valid8(lat);
        n_cmp++; if (lat !== 7) begin n_bad++; $display("FAIL busy_second_latency got=%0d want=7", lat); end
        exp = (q8.size() != 0) ? q8.pop_front() : 12'hxxx;
        n_cmp++; if (m8.o_Bcd !== exp) begin n_bad++; $display("FAIL busy_second_bcd got=%h want=%h", m8.o_Bcd, exp); end
        $display("test_busy_reject second value=55 bcd=%h", m8.o_Bcd);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic late;
        m8.i_Ready = 1'b1;
        drive8(200);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (m8.o_Bcd !== 12'h000) begin n_bad++; $display("FAIL rst_mid_bcd got=%h want=000", m8.o_Bcd); end
        n_cmp++; if (m8.o_Valid !== 1'b0 || m8.o_Ready !== 1'b1 || m8.o_Busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_flags valid=%b ready=%b busy=%b want 0/1/0", m8.o_Valid, m8.o_Ready, m8.o_Busy);
        end
        q8.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (m8.o_Valid || !m8.o_Ready) late = 1'b1;
        end
        n_cmp++; if (late !== 1'b0) begin n_bad++; $display("FAIL rst_mid_late_result got=%b want=0", late); end
        $display("test_reset_mid value=200 bcd=%h", m8.o_Bcd);
    endtask

    task automatic test_width16();
        int          vals[2] = '{65535, 10000};
        int          lat;
        logic [19:0] exp;
        m16.i_Ready = 1'b1;
        foreach (vals[i]) begin
            drive16(vals[i]);
            wait_valid16(lat);
            n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL w16_latency got=%0d want=16", lat); end
            exp = (q16.size() != 0) ? q16.pop_front() : 20'hxxxxx;
            n_cmp++; if (m16.o_Bcd !== exp) begin n_bad++; $display("FAIL w16_bcd value=%0d got=%h want=%h", vals[i], m16.o_Bcd, exp); end
            $display("test_width16 value=%0d bcd=%h", vals[i], m16.o_Bcd);
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_fib_sequence();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
        test_width16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
